// File: rtl/uart_pkg.sv
// Shared definitions for the LC-3 UART transmit path.
//
// Contents:
//   uart_state_e  - transmitter state encoding (IDLE, START, DATA, PARITY,
//                   STOP, CLEANUP)
//   DSR_READY_BIT - bit of the LC-3 DSR word that reports "ready for a write"
//   clog2()       - ceiling log2, used for counter and pointer widths
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    START   = 3'd1,
    DATA    = 3'd2,
    PARITY  = 3'd3,
    STOP    = 3'd4,
    CLEANUP = 3'd5
  } uart_state_e;

  localparam int DSR_READY_BIT = 15;

  // Number of bits needed to hold values 0 .. value-1.
  function automatic int clog2(input int value);
    int result;
    int remain;
    result = 0;
    remain = value - 1;
    while (remain > 0) begin
      result = result + 1;
      remain = remain >> 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/uart_tx_fifo_buf.sv
// Synchronous FIFO that queues bytes for the UART transmitter.
//
// Ports:
//   clk_i        - clock, all state on posedge
//   rst_ni       - synchronous active-low reset, empties the FIFO
//   push_i       - write request; accepted when not full, or when full
//                  and a pop happens on the same edge
//   pop_i        - read request; ignored when empty
//   data_i       - word written on an accepted push
//   data_o       - head of the FIFO (show-ahead, valid when !empty_o)
//   full_o       - count == DEPTH
//   empty_o      - count == 0
//   count_o      - current occupancy
//   count_next_o - occupancy after the current edge's push/pop
module uart_tx_fifo_buf
  import uart_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int AW = clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic             pop_i,
  input  logic [WIDTH-1:0] data_i,
  output logic [WIDTH-1:0] data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic [CW-1:0]    count_o,
  output logic [CW-1:0]    count_next_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             push_ok;
  logic             pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // A pop frees a slot on the same edge, so a push while full still lands
  // when it coincides with a pop.
  assign pop_ok  = pop_i && !empty_o;
  assign push_ok = push_i && (!full_o || pop_ok);

  always_comb begin
    count_d = count_q;
    if (push_ok && !pop_ok) begin
      count_d = count_q + CW'(1);
    end else if (!push_ok && pop_ok) begin
      count_d = count_q - CW'(1);
    end
  end

  // DEPTH is a power of two, so the pointers wrap by plain overflow.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_ok)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (push_ok) mem_q[wr_ptr_q] <= data_i;
  end

  assign data_o       = mem_q[rd_ptr_q];
  assign count_o      = count_q;
  assign count_next_o = count_d;

endmodule

// File: rtl/uart_tx_fifo_ctrl.sv
// UART transmitter with TX FIFO for the LC-3 memory-mapped display path.
// Bytes queued through a one-cycle write strobe are sent LSB first with a
// start bit, DATA_BITS data bits, an optional parity bit and 1 or 2 stops.
//
// Optional feature: define UART_TX_PARITY_EN to build the PARITY state.
// Without it the parity inputs are ignored and frames go DATA -> STOP.
//
// Ports:
//   i_Clock      - clock, all logic on posedge
//   i_Rst_n      - synchronous active-low reset (aborts any frame)
//   i_Wr_En      - one-cycle write strobe
//   i_Wr_Data    - byte queued when i_Wr_En=1
//   i_Parity_En  - insert a parity bit after the data
//   i_Parity_Odd - 1 = odd parity, 0 = even
//   i_Two_Stop   - 1 = two stop bits
//   o_DSR        - LC-3 status word, bit 15 = ready for a write
//   o_Ready      - FIFO not full
//   o_Tx_Serial  - serial line, idle high
//   o_Tx_Active  - high for every line clock from start bit to last stop
//   o_Tx_Done    - one-cycle pulse right after the final stop bit
//   o_Overrun    - one-cycle pulse when a write is dropped
module uart_tx_fifo_ctrl
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 870,
  parameter int DATA_BITS    = 8,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                 i_Clock,
  input  logic                 i_Rst_n,
  input  logic                 i_Wr_En,
  input  logic [DATA_BITS-1:0] i_Wr_Data,
  input  logic                 i_Parity_En,
  input  logic                 i_Parity_Odd,
  input  logic                 i_Two_Stop,
  output logic [15:0]          o_DSR,
  output logic                 o_Ready,
  output logic                 o_Tx_Serial,
  output logic                 o_Tx_Active,
  output logic                 o_Tx_Done,
  output logic                 o_Overrun
);

  localparam int CNT_W = clog2(CLKS_PER_BIT * 2);
  localparam int IDX_W = clog2(DATA_BITS);
  localparam int FCW   = clog2(FIFO_DEPTH) + 1;

  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] STOP2_LAST = CNT_W'(2 * CLKS_PER_BIT - 1);
  localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(DATA_BITS - 1);

  uart_state_e          state_q, state_d;
  logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
  logic [IDX_W-1:0]     bit_idx_q, bit_idx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 two_stop_q, two_stop_d;
  logic                 tx_q, tx_d;
  logic                 active_q, active_d;
  logic                 done_q, done_d;
  logic                 overrun_q, overrun_d;
  logic                 ready_q, ready_d;

  logic [DATA_BITS-1:0] fifo_data;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic                 fifo_pop;
  logic [FCW-1:0]       unused_fifo_count;
  logic [FCW-1:0]       fifo_count_next;

`ifdef UART_TX_PARITY_EN
  logic par_en_q, par_en_d;
  logic par_bit_q, par_bit_d;
`else
  logic [1:0] unused_parity_cfg;
  assign unused_parity_cfg = {i_Parity_En, i_Parity_Odd};
`endif

  // The FSM only takes a new byte while idle.
  assign fifo_pop = (state_q == IDLE) && !fifo_empty;

  uart_tx_fifo_buf #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk_i        (i_Clock),
    .rst_ni       (i_Rst_n),
    .push_i       (i_Wr_En),
    .pop_i        (fifo_pop),
    .data_i       (i_Wr_Data),
    .data_o       (fifo_data),
    .full_o       (fifo_full),
    .empty_o      (fifo_empty),
    .count_o      (unused_fifo_count),
    .count_next_o (fifo_count_next)
  );

  // Frame sequencing. Configuration is captured at the pop so that input
  // changes during a frame only affect the following frame. Parity is
  // computed from the whole byte at capture time because the shift
  // register is consumed as the data bits go out.
  always_comb begin
    state_d    = state_q;
    clk_cnt_d  = clk_cnt_q;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    two_stop_d = two_stop_q;
`ifdef UART_TX_PARITY_EN
    par_en_d   = par_en_q;
    par_bit_d  = par_bit_q;
`endif
    case (state_q)
      IDLE: begin
        if (!fifo_empty) begin
          shift_d    = fifo_data;
          two_stop_d = i_Two_Stop;
`ifdef UART_TX_PARITY_EN
          par_en_d   = i_Parity_En;
          par_bit_d  = (^fifo_data) ^ i_Parity_Odd;
`endif
          clk_cnt_d  = '0;
          bit_idx_d  = '0;
          state_d    = START;
        end
      end
      START: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = DATA;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          if (bit_idx_q == IDX_LAST) begin
            bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
            state_d   = par_en_q ? PARITY : STOP;
`else
            state_d   = STOP;
`endif
          end else begin
            bit_idx_d = bit_idx_q + IDX_W'(1);
            shift_d   = shift_q >> 1;
          end
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_d = '0;
          state_d   = STOP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
`endif
      STOP: begin
        if (clk_cnt_q == (two_stop_q ? STOP2_LAST : BIT_LAST)) begin
          clk_cnt_d = '0;
          state_d   = CLEANUP;
        end else begin
          clk_cnt_d = clk_cnt_q + CNT_W'(1);
        end
      end
      CLEANUP: begin
        state_d = IDLE;
      end
      default: begin
        state_d   = IDLE;
        clk_cnt_d = '0;
        bit_idx_d = '0;
      end
    endcase
  end

  // Line-side outputs are registered from the current state, so the line
  // trails the state by one clock; active and done follow the same delay
  // and stay aligned with the bits on the wire.
  always_comb begin
    tx_d = 1'b1;
    case (state_q)
      START:  tx_d = 1'b0;
      DATA:   tx_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY: tx_d = par_bit_q;
`endif
      default: tx_d = 1'b1;
    endcase
    active_d  = (state_q == START) || (state_q == DATA) ||
                (state_q == PARITY) || (state_q == STOP);
    done_d    = (state_q == CLEANUP);
    overrun_d = i_Wr_En && fifo_full && !fifo_pop;
    ready_d   = (fifo_count_next != FCW'(FIFO_DEPTH));
  end

  // Reset lands on the same edge for the line and all status outputs, so
  // an aborted frame leaves the line high immediately.
  always_ff @(posedge i_Clock) begin
    if (!i_Rst_n) begin
      state_q    <= IDLE;
      clk_cnt_q  <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      two_stop_q <= 1'b0;
      tx_q       <= 1'b1;
      active_q   <= 1'b0;
      done_q     <= 1'b0;
      overrun_q  <= 1'b0;
      ready_q    <= 1'b1;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= 1'b0;
      par_bit_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      clk_cnt_q  <= clk_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      two_stop_q <= two_stop_d;
      tx_q       <= tx_d;
      active_q   <= active_d;
      done_q     <= done_d;
      overrun_q  <= overrun_d;
      ready_q    <= ready_d;
`ifdef UART_TX_PARITY_EN
      par_en_q   <= par_en_d;
      par_bit_q  <= par_bit_d;
`endif
    end
  end

  always_comb begin
    o_DSR                = '0;
    o_DSR[DSR_READY_BIT] = ready_q;
  end

  assign o_Ready     = ready_q;
  assign o_Tx_Serial = tx_q;
  assign o_Tx_Active = active_q;
  assign o_Tx_Done   = done_q;
  assign o_Overrun   = overrun_q;

endmodule

// File: tb/tb_uart_tx_fifo_ctrl.sv
// Self-checking bench for uart_tx_fifo_ctrl. A scoreboard queue holds the
// frames expected on the line; a monitor decodes the serial output clock
// by clock and compares each frame against the head of the queue.
module tb_uart_tx_fifo_ctrl;

  localparam int CPB     = 4;
  localparam int DB      = 8;
  localparam int DEPTH   = 4;
  localparam int TIMEOUT = 3000;

`ifdef UART_TX_PARITY_EN
  localparam bit PAR_BUILT = 1'b1;
`else
  localparam bit PAR_BUILT = 1'b0;
`endif

  typedef struct packed {
    logic [7:0] data;
    logic       par;
    logic       odd;
    logic       two;
  } frame_t;

  logic        clock;
  logic        rstN;
  logic        wrEn;
  logic [7:0]  wrData;
  logic        parEn;
  logic        parOdd;
  logic        twoStop;
  logic [15:0] dsr;
  logic        ready;
  logic        serial;
  logic        active;
  logic        done;
  logic        overrun;

  logic        wrEn5;
  logic [4:0]  wrData5;
  logic [15:0] dsr5;
  logic        ready5;
  logic        serial5;
  logic        active5;
  logic        done5;
  logic        overrun5;

  frame_t expQ[$];
  int     total = 0;
  int     bad = 0;
  bit     monBusy = 1'b0;

  uart_tx_fifo_ctrl #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (DB),
    .FIFO_DEPTH   (DEPTH)
  ) u_dut (
    .i_Clock      (clock),
    .i_Rst_n      (rstN),
    .i_Wr_En      (wrEn),
    .i_Wr_Data    (wrData),
    .i_Parity_En  (parEn),
    .i_Parity_Odd (parOdd),
    .i_Two_Stop   (twoStop),
    .o_DSR        (dsr),
    .o_Ready      (ready),
    .o_Tx_Serial  (serial),
    .o_Tx_Active  (active),
    .o_Tx_Done    (done),
    .o_Overrun    (overrun)
  );

  uart_tx_fifo_ctrl #(
    .CLKS_PER_BIT (CPB),
    .DATA_BITS    (5),
    .FIFO_DEPTH   (DEPTH)
  ) u_dut5 (
    .i_Clock      (clock),
    .i_Rst_n      (rstN),
    .i_Wr_En      (wrEn5),
    .i_Wr_Data    (wrData5),
    .i_Parity_En  (parEn),
    .i_Parity_Odd (parOdd),
    .i_Two_Stop   (1'b0),
    .o_DSR        (dsr5),
    .o_Ready      (ready5),
    .o_Tx_Serial  (serial5),
    .o_Tx_Active  (active5),
    .o_Tx_Done    (done5),
    .o_Overrun    (overrun5)
  );

  // 10 ns clock
  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  // Hard stop in case something wedges outside the bounded waits.
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got=timeout want=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  // Single comparison point for the whole bench.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got=%0h want=%0h", tag, observed, expected);
    end
  endtask

  // Advance to 2 ns after the next rising edge, where inputs are driven
  // and registered outputs are checked.
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #2;
  endtask

  // Drive one write strobe (caller sits at posedge+2) and, if the write is
  // expected to be accepted, queue the frame that should appear on the line.
  task automatic applyStimulus(input logic [7:0] data, input bit accepted);
    frame_t f;
    wrEn   = 1'b1;
    wrData = data;
    if (accepted) begin
      f.data = data;
      f.par  = PAR_BUILT & parEn;
      f.odd  = parOdd;
      f.two  = twoStop;
      expQ.push_back(f);
    end
    tick(1);
    wrEn = 1'b0;
  endtask

  task automatic waitDrain();
    int k;
    k = 0;
    while ((expQ.size() != 0 || monBusy || active) && k < TIMEOUT) begin
      tick(1);
      k++;
    end
    checkOutput("drainInTime", 32'(k < TIMEOUT), 32'd1);
    tick(2);
  endtask

  task automatic waitActive();
    int k;
    k = 0;
    while (active !== 1'b1 && k < TIMEOUT) begin
      tick(1);
      k++;
    end
    checkOutput("activeInTime", 32'(k < TIMEOUT), 32'd1);
  endtask

  task automatic waitDone();
    int k;
    k = 0;
    while (done !== 1'b1 && k < TIMEOUT) begin
      tick(1);
      k++;
    end
    checkOutput("doneInTime", 32'(k < TIMEOUT), 32'd1);
  endtask

  // Decode one frame whose start bit was just seen at this negedge.
  task automatic runFrame();
    frame_t      f;
    logic [11:0] want;
    logic [11:0] got;
    int          n;
    int          unstable;
    int          activeMiss;
    int          doneEarly;
    bit          aborted;
    monBusy    = 1'b1;
    unstable   = 0;
    activeMiss = 0;
    doneEarly  = 0;
    aborted    = 1'b0;
    if (expQ.size() == 0) begin
      checkOutput("unexpectedFrame", 32'd1, 32'd0);
      f = '0;
    end else begin
      f = expQ.pop_front();
    end
    want    = '0;
    want[0] = 1'b0;
    for (int i = 0; i < DB; i++) want[1+i] = f.data[i];
    n = 1 + DB;
    if (f.par) begin
      want[n] = (^f.data) ^ f.odd;
      n++;
    end
    want[n] = 1'b1;
    n++;
    if (f.two) begin
      want[n] = 1'b1;
      n++;
    end
    got = '0;
    for (int b = 0; b < n && !aborted; b++) begin
      for (int c = 0; c < CPB && !aborted; c++) begin
        if (!(b == 0 && c == 0)) @(negedge clock);
        if (!rstN) begin
          aborted = 1'b1;
        end else begin
          if (c == 0) got[b] = serial;
          else if (serial !== got[b]) unstable++;
          if (active !== 1'b1) activeMiss++;
          if (done !== 1'b0) doneEarly++;
        end
      end
    end
    if (!aborted) begin
      checkOutput("frameBits", 32'(got), 32'(want));
      checkOutput("bitWidth", 32'(unstable), 32'd0);
      checkOutput("activeInFrame", 32'(activeMiss), 32'd0);
      checkOutput("doneEarly", 32'(doneEarly), 32'd0);
      @(negedge clock);
      checkOutput("donePulse", 32'(done), 32'd1);
      checkOutput("activeAfter", 32'(active), 32'd0);
      @(negedge clock);
      checkOutput("doneSingle", 32'(done), 32'd0);
    end
    monBusy = 1'b0;
  endtask

  // Line monitor: a low line outside a frame is a start bit.
  initial begin
    forever begin
      @(negedge clock);
      if (rstN === 1'b1 && serial === 1'b0) runFrame();
    end
  end

  initial begin
    int cnt;
    rstN    = 1'b0;
    wrEn    = 1'b0;
    wrData  = '0;
    parEn   = 1'b0;
    parOdd  = 1'b0;
    twoStop = 1'b0;
    wrEn5   = 1'b0;
    wrData5 = '0;

    // Reset state
    repeat (2) @(posedge clock);
    #1;
    checkOutput("rstSerial", 32'(serial), 32'd1);
    checkOutput("rstActive", 32'(active), 32'd0);
    checkOutput("rstDone", 32'(done), 32'd0);
    checkOutput("rstOverrun", 32'(overrun), 32'd0);
    checkOutput("rstReady", 32'(ready), 32'd1);
    checkOutput("rstDsr", 32'(dsr), 32'h8000);
    #1;
    rstN = 1'b1;
    tick(2);

    // 8'hA5, no parity, one stop: start bit two edges after the write
    applyStimulus(8'hA5, 1'b1);
    checkOutput("latN", 32'(serial), 32'd1);
    @(posedge clock);
    #1;
    checkOutput("latN1Serial", 32'(serial), 32'd1);
    checkOutput("latN1Active", 32'(active), 32'd0);
    @(posedge clock);
    #1;
    checkOutput("latN2Serial", 32'(serial), 32'd0);
    checkOutput("latN2Active", 32'(active), 32'd1);
    #1;
    waitDrain();

    // Even then odd parity on 8'h07, then two stop bits
    parEn  = 1'b1;
    parOdd = 1'b0;
    applyStimulus(8'h07, 1'b1);
    waitDrain();
    parOdd = 1'b1;
    applyStimulus(8'h07, 1'b1);
    waitDrain();
    parEn   = 1'b0;
    twoStop = 1'b1;
    applyStimulus(8'hC3, 1'b1);
    waitDrain();

    // Configuration flipped mid-frame must not disturb the current frame
    parEn   = 1'b1;
    parOdd  = 1'b1;
    twoStop = 1'b1;
    applyStimulus(8'h3C, 1'b1);
    waitActive();
    parEn   = 1'b0;
    parOdd  = 1'b0;
    twoStop = 1'b0;
    waitDrain();

    // Fill the FIFO behind a frame in flight, then overflow it
    applyStimulus(8'h11, 1'b1);
    waitActive();
    applyStimulus(8'h22, 1'b1);
    applyStimulus(8'h33, 1'b1);
    applyStimulus(8'h44, 1'b1);
    checkOutput("readyAt3", 32'(ready), 32'd1);
    applyStimulus(8'h55, 1'b1);
    checkOutput("readyFull", 32'(ready), 32'd0);
    checkOutput("dsrFull", 32'(dsr), 32'h0000);
    checkOutput("noOverrunYet", 32'(overrun), 32'd0);
    applyStimulus(8'h66, 1'b0);
    checkOutput("overrunPulse", 32'(overrun), 32'd1);
    tick(1);
    checkOutput("overrunSingle", 32'(overrun), 32'd0);
    waitDone();
    checkOutput("dsrBeforePop", 32'(dsr), 32'h0000);
    tick(1);
    checkOutput("dsrAfterPop", 32'(dsr), 32'h8000);

    // Refill, then push while full on the edge where IDLE pops
    applyStimulus(8'h77, 1'b1);
    checkOutput("readyRefull", 32'(ready), 32'd0);
    waitDone();
    applyStimulus(8'h88, 1'b1);
    checkOutput("noOverrunOnPop", 32'(overrun), 32'd0);
    checkOutput("dsrStillFull", 32'(dsr), 32'h0000);
    waitDrain();

    // Reset in the middle of the data bits
    applyStimulus(8'h5A, 1'b1);
    waitActive();
    tick(6);
    rstN = 1'b0;
    @(posedge clock);
    #1;
    checkOutput("abortSerial", 32'(serial), 32'd1);
    checkOutput("abortActive", 32'(active), 32'd0);
    checkOutput("abortDsr", 32'(dsr), 32'h8000);
    #1;
    rstN = 1'b1;
    expQ.delete();
    cnt = 0;
    repeat (60) begin
      tick(1);
      if (done === 1'b1) cnt++;
    end
    checkOutput("noDoneAfterAbort", 32'(cnt), 32'd0);
    checkOutput("idleAfterAbort", 32'(serial), 32'd1);

    // Five-bit instance with parity requested
    parEn   = 1'b1;
    wrEn5   = 1'b1;
    wrData5 = 5'h15;
    tick(1);
    wrEn5 = 1'b0;
    cnt = 0;
    while (active5 !== 1'b1 && cnt < TIMEOUT) begin
      tick(1);
      cnt++;
    end
    checkOutput("active5InTime", 32'(cnt < TIMEOUT), 32'd1);
    cnt = 0;
    while (active5 === 1'b1 && cnt < TIMEOUT) begin
      cnt++;
      tick(1);
    end
    checkOutput("frame5Length", 32'(cnt), 32'((PAR_BUILT ? 8 : 7) * CPB));
    checkOutput("frame5Done", 32'(done5), 32'd1);
    parEn = 1'b0;
    tick(4);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_fifo_ctrl.md
Name: uart_tx_fifo_ctrl

Overview:
Parametrised next-generation UART transmitter for the LC-3 memory-mapped display path. It accepts bytes through a DDR-style write strobe into a small TX FIFO and serialises them LSB-first with configurable data bits, optional parity and 1 or 2 stop bits. It exports an LC-3 DSR word whose bit 15 means "ready for a write", replacing the single-shot DSR==1 trigger. It sits between the memory-mapped I/O decode and the board TX pin.

Parameters:
CLKS_PER_BIT, 870, clocks per serial bit (i_Clock freq / baud); ≥2.
DATA_BITS, 8, payload bits per frame; 5..8.
FIFO_DEPTH, 4, TX FIFO entries; power of 2, ≥2.

Ports:
i_Clock  in  1  system clock; all logic on posedge.
i_Rst_n  in  1  synchronous active-low reset.
i_Wr_En  in  1  one-cycle DDR write strobe.
i_Wr_Data  in  DATA_BITS  byte to queue, sampled when i_Wr_En=1.
i_Parity_En  in  1  1 = insert parity bit after data.
i_Parity_Odd  in  1  1 = odd parity, 0 = even.
i_Two_Stop  in  1  1 = two stop bits.
o_DSR  out  16  {o_Ready, 15'b0}.
o_Ready  out  1  FIFO not full.
o_Tx_Serial  out  1  serial line, idle high.
o_Tx_Active  out  1  frame in progress (START..STOP).
o_Tx_Done  out  1  one-cycle pulse after final stop bit.
o_Overrun  out  1  one-cycle pulse when a write is dropped.

Behaviour:
- Reset (i_Rst_n=0 at posedge): o_Tx_Serial=1, o_Tx_Active=0, o_Tx_Done=0, o_Overrun=0, FIFO emptied, o_Ready=1, o_DSR=16'h8000, state IDLE, counters 0. Reset mid-frame aborts the frame; line returns high on the same edge.
- FIFO: push on i_Wr_En && !full. Push while full is dropped and pulses o_Overrun next cycle. Pop occurs only in IDLE when not empty. Simultaneous push and pop while full: both occur, no overrun. Pointers wrap modulo FIFO_DEPTH. Count width is $clog2(FIFO_DEPTH)+1.
- o_Ready and o_DSR are registered from the post-update FIFO count.
- State machine:
  - IDLE: line 1. If FIFO is not empty, pop into the shift register, latch the parity, mode and stop configuration for the whole frame, and go to START.
  - START: line 0 for CLKS_PER_BIT clocks, then DATA.
  - DATA: bit index 0..DATA_BITS-1, LSB first, CLKS_PER_BIT clocks each. After the last bit, go to PARITY if parity is enabled, else STOP.
  - PARITY: line = XOR of data bits, XOR i_Parity_Odd (latched). Lasts CLKS_PER_BIT clocks, then STOP.
  - STOP: line 1 for CLKS_PER_BIT clocks, or 2×CLKS_PER_BIT if two stop bits are latched. Then CLEANUP.
  - CLEANUP: 1 clock, o_Tx_Done=1, then IDLE.
- Latency: a write into an empty FIFO while in IDLE at edge N gives the start bit on o_Tx_Serial from edge N+2. Every bit lasts exactly CLKS_PER_BIT clocks.
- Back-to-back frames: minimum gap between stop end and the next start is 2 clocks (CLEANUP plus IDLE pop).
- o_Tx_Active is 1 from START entry through the last STOP clock.
- Config inputs changed mid-frame do not affect the current frame.
- Bit counter width is $clog2(CLKS_PER_BIT*2). No counter ever exceeds its terminal value.

Optional Feature:
Macro UART_TX_PARITY_EN.
- Defined: PARITY state and the parity inputs are active as above.
- Undefined: PARITY state and the parity logic are not synthesised. i_Parity_En and i_Parity_Odd are ignored, and frames always go DATA→STOP. The ports remain present.

Decomposition:
- Package uart_pkg: state enum (IDLE, START, DATA, PARITY, STOP, CLEANUP), DSR_READY_BIT=15, and a clog2 helper function.
- Sub-module uart_tx_fifo_buf: synchronous FIFO parametrised by width and depth, with push/pop/full/empty/count outputs.
- The top module holds the FSM, the baud counter and the shift register.

Test Plan:
- CLKS_PER_BIT=4, DATA_BITS=8, no parity, 1 stop. Write 8'hA5 → start bit at N+2. Line reads 0,1,0,1,0,0,1,0,1,1 with each bit 4 clocks. o_Tx_Done pulses once. o_Tx_Active is high for 40 clocks.
- Parity even with 8'h07 → parity bit 1. Parity odd with 8'h07 → parity bit 0. Two stop bits → stop high for 8 clocks before o_Tx_Done.
- FIFO_DEPTH=4, write 5 bytes on consecutive clocks → o_Ready=0 after the 4th write, the 5th write pulses o_Overrun, and exactly 4 frames are transmitted in order. o_DSR returns to 16'h8000 after the first pop.
- Push while full on the same cycle IDLE pops → write accepted, no o_Overrun, and 4 subsequent frames are transmitted.
- Assert i_Rst_n=0 for 1 clock in the middle of the DATA bits → next cycle o_Tx_Serial=1, o_Tx_Active=0, o_DSR=16'h8000, and no o_Tx_Done pulse follows.
- DATA_BITS=5 with UART_TX_PARITY_EN undefined and i_Parity_En=1 → frame is 1 start + 5 data + 1 stop = 7×CLKS_PER_BIT clocks.
